// File: rtl/fb_pkg.sv
// Shared constants and state type for the 1-bit framebuffer writer.
// Geometry is 320x200 pixels, stored across four 16Kx1 banks.
package fb_pkg;
  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 200;
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int BANK_AW   = 14;

  localparam logic [1:0] OP_SET   = 2'd0;
  localparam logic [1:0] OP_FILL  = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PIXEL,
    ST_RECT,
    ST_CLEAR
  } state_t;
endpackage

// File: rtl/fb_scan_gen.sv
// Row-major rectangle scanner with inclusive bounds.
// The linear address advances incrementally; no multiply in the loop.
module fb_scan_gen
  import fb_pkg::*;
#(
  parameter int WIDTH = FB_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        adv,
  input  logic [8:0]  x0,
  input  logic [7:0]  y0,
  input  logic [8:0]  x1,
  input  logic [7:0]  y1,
  output logic [15:0] addr,
  output logic        last
);
  logic [8:0]  x, xs, xe;
  logic [7:0]  y, ye;
  logic [15:0] row;
  logic [15:0] base;

  if (WIDTH == 320) begin : g_shift
    assign base = ({8'd0, y0} << 8) + ({8'd0, y0} << 6);
  end else begin : g_mul
    assign base = 16'(32'(y0) * WIDTH);
  end

  // row holds the address of the first pixel of the current row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x    <= '0;
      xs   <= '0;
      xe   <= '0;
      y    <= '0;
      ye   <= '0;
      row  <= '0;
      addr <= '0;
    end else if (load) begin
      x    <= x0;
      xs   <= x0;
      xe   <= x1;
      y    <= y0;
      ye   <= y1;
      row  <= base + 16'(x0);
      addr <= base + 16'(x0);
    end else if (adv) begin
      if (x == xe) begin
        x    <= xs;
        y    <= y + 8'd1;
        row  <= row + 16'(WIDTH);
        addr <= row + 16'(WIDTH);
      end else begin
        x    <= x + 9'd1;
        addr <= addr + 16'd1;
      end
    end
  end

  assign last = (x == xe) && (y == ye);
endmodule

// File: rtl/fb_writer.sv
// Drawing engine: set pixel, fill rectangle, clear screen.
// Emits one registered pixel write per clock to the banked RAM.
module fb_writer
  import fb_pkg::*;
#(
  parameter int WIDTH   = FB_WIDTH,
  parameter int HEIGHT  = FB_HEIGHT,
  parameter int BANK_AW = fb_pkg::BANK_AW
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [8:0]  cmd_x0,
  input  logic [7:0]  cmd_y0,
  input  logic [8:0]  cmd_x1,
  input  logic [7:0]  cmd_y1,
  input  logic        cmd_color,
  output logic        wr_en,
  output logic [13:0] wr_addr,
  output logic [1:0]  wr_bank,
  output logic        wr_data,
  output logic        busy,
  output logic        cmd_err
);
  state_t      state, state_d;
  logic        wr_en_d, err_d, data_d;
  logic        load, adv, full;
  logic [8:0]  x1c, sx0, sx1;
  logic [7:0]  y1c, sy0, sy1;
  logic        px_ok, rect_ok;
  logic [15:0] addr;
  logic        last;

  assign x1c = (cmd_x1 > 9'(WIDTH - 1)) ? 9'(WIDTH - 1) : cmd_x1;
  assign y1c = (cmd_y1 > 8'(HEIGHT - 1)) ? 8'(HEIGHT - 1) : cmd_y1;
  assign px_ok = (cmd_x0 < 9'(WIDTH)) && (cmd_y0 < 8'(HEIGHT));
  assign rect_ok = px_ok && (cmd_x0 <= x1c) && (cmd_y0 <= y1c);

  assign sx0 = full ? 9'd0 : cmd_x0;
  assign sy0 = full ? 8'd0 : cmd_y0;
  assign sx1 = full ? 9'(WIDTH - 1) : x1c;
  assign sy1 = full ? 8'(HEIGHT - 1) : y1c;

  always_comb begin
    state_d = state;
    wr_en_d = 1'b0;
    err_d   = 1'b0;
    data_d  = wr_data;
    load    = 1'b0;
    adv     = 1'b0;
    full    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          data_d = cmd_color;
          // rejected commands spend one busy cycle in PIXEL
          state_d = ST_PIXEL;
          unique case (cmd_op)
            OP_SET: begin
              load    = px_ok;
              wr_en_d = px_ok;
              err_d   = ~px_ok;
            end
            OP_FILL: begin
              load    = rect_ok;
              wr_en_d = rect_ok;
              err_d   = ~rect_ok;
              if (rect_ok) state_d = ST_RECT;
            end
            OP_CLEAR: begin
              full    = 1'b1;
              load    = 1'b1;
              wr_en_d = 1'b1;
              state_d = ST_CLEAR;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_PIXEL: state_d = ST_IDLE;
      ST_RECT, ST_CLEAR: begin
        if (last) begin
          state_d = ST_IDLE;
        end else begin
          adv     = 1'b1;
          wr_en_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      wr_en   <= 1'b0;
      cmd_err <= 1'b0;
      wr_data <= 1'b0;
    end else begin
      state   <= state_d;
      wr_en   <= wr_en_d;
      cmd_err <= err_d;
      wr_data <= data_d;
    end
  end

  fb_scan_gen #(.WIDTH(WIDTH)) u_scan (
    .clk  (clk),
    .rst  (reset),
    .load (load),
    .adv  (adv),
    .x0   (sx0),
    .y0   (sy0),
    .x1   (sx1),
    .y1   (sy1),
    .addr (addr),
    .last (last)
  );

  assign wr_addr   = addr[BANK_AW-1:0];
  assign wr_bank   = addr[15:BANK_AW];
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = ~cmd_ready;
endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer against a pixel-list model.
// Random and directed commands; write sequences checked in order.
module tb_fb_writer;
  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [8:0] cmd_x0, cmd_x1;
  logic [7:0] cmd_y0, cmd_y1;
  logic       cmd_color;
  logic       wr_en;
  logic [13:0] wr_addr;
  logic [1:0] wr_bank;
  logic       wr_data;
  logic       busy;
  logic       cmd_err;

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  fb_writer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_x1    (cmd_x1),
    .cmd_y1    (cmd_y1),
    .cmd_color (cmd_color),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_bank   (wr_bank),
    .wr_data   (wr_data),
    .busy      (busy),
    .cmd_err   (cmd_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    vec++;
    assert (obs === exp_v) else begin
      miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic [1:0] op, input int x0, input int y0,
                       input int x1, input int y1, input logic c);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x0    = 9'(x0);
    cmd_y0    = 8'(y0);
    cmd_x1    = 9'(x1);
    cmd_y1    = 8'(y1);
    cmd_color = c;
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op,
                         input int x0, input int y0, input int x1,
                         input int y1, input logic c, input bit hold);
    int exp_q[$];
    int exp_err = 0;
    int nw = 0, nerr = 0, cyc = 0, bad = 0, bad_d = 0;
    int cx1, cy1, lin, first_en;
    bit tmo = 0;
    cx1 = (x1 > 319) ? 319 : x1;
    cy1 = (y1 > 199) ? 199 : y1;
    if (op == 2'd0) begin
      if (x0 < 320 && y0 < 200) exp_q.push_back(y0 * 320 + x0);
      else exp_err = 1;
    end else if (op == 2'd1) begin
      if (x0 >= 320 || y0 >= 200 || x0 > cx1 || y0 > cy1) exp_err = 1;
      else
        for (int yy = y0; yy <= cy1; yy++)
          for (int xx = x0; xx <= cx1; xx++)
            exp_q.push_back(yy * 320 + xx);
    end else if (op == 2'd2) begin
      for (int i = 0; i < 64000; i++) exp_q.push_back(i);
    end else begin
      exp_err = 1;
    end

    @(negedge clk);
    chk({tag, "_ready_before"}, 32'(cmd_ready), 1);
    drive(op, x0, y0, x1, y1, c);
    @(posedge clk);
    #1;
    cmd_valid = hold;
    cmd_color = ~c;
    cmd_op    = 2'd0;
    cmd_x0    = 9'($urandom_range(0, 319));
    first_en  = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      cyc++;
      if (cyc == 1) first_en = int'(wr_en);
      if (busy !== 1'b1) bad++;
      if (wr_en) begin
        lin = int'({wr_bank, wr_addr});
        if (nw >= exp_q.size() || lin != exp_q[nw]) bad++;
        if (wr_data !== c) bad_d++;
        nw++;
      end
      if (cmd_err) nerr++;
      if (cyc > exp_q.size() + 4) begin
        tmo = 1;
        break;
      end
    end
    cmd_valid = 1'b0;
    chk({tag, "_timeout"}, 32'(tmo), 0);
    chk({tag, "_nwrites"}, nw, exp_q.size());
    chk({tag, "_addr_seq_bad"}, bad, 0);
    chk({tag, "_data_bad"}, bad_d, 0);
    chk({tag, "_err_pulses"}, nerr, exp_err);
    chk({tag, "_busy_cycles"}, cyc,
        (exp_q.size() > 0) ? exp_q.size() : 1);
    if (exp_q.size() > 0) chk({tag, "_first_latency"}, first_en, 1);
  endtask

  initial begin
    int r, x0, y0, x1, y1, n;
    bit tmo;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_x0 = '0;
    cmd_y0 = '0;
    cmd_x1 = '0;
    cmd_y1 = '0;
    cmd_color = 1'b0;
    #1;
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_addr", 32'({wr_bank, wr_addr}), 0);
    chk("rst_data", 32'(wr_data), 0);
    chk("rst_err", 32'(cmd_err), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_cmd("set_5_3", 2'd0, 5, 3, 0, 0, 1'b1, 0);
    run_cmd("set_corner", 2'd0, 319, 199, 0, 0, 1'b1, 0);
    run_cmd("set_oob", 2'd0, 320, 0, 0, 0, 1'b1, 0);
    run_cmd("fill_6", 2'd1, 10, 20, 12, 21, 1'b0, 0);
    run_cmd("fill_clamp", 2'd1, 318, 0, 400, 255, 1'b1, 0);
    run_cmd("fill_inv", 2'd1, 5, 0, 4, 0, 1'b1, 0);
    run_cmd("op3", 2'd3, 0, 0, 0, 0, 1'b1, 0);
    run_cmd("clear_hold", 2'd2, 0, 0, 0, 0, 1'b1, 1);

    for (int i = 0; i < 30; i++) begin
      r  = $urandom_range(0, 9);
      x0 = $urandom_range(0, 325);
      y0 = $urandom_range(0, 205);
      x1 = x0 + $urandom_range(0, 7) - 1;
      y1 = y0 + $urandom_range(0, 4) - 1;
      if (x1 < 0) x1 = 0;
      if (y1 < 0) y1 = 0;
      if (x1 > 511) x1 = 511;
      if (y1 > 255) y1 = 255;
      if (r < 4)
        run_cmd("rnd_set", 2'd0, x0, y0, 0, 0, 1'($urandom), 0);
      else if (r < 9)
        run_cmd("rnd_fill", 2'd1, x0, y0, x1, y1, 1'($urandom), 0);
      else
        run_cmd("rnd_op3", 2'd3, x0, y0, x1, y1, 1'($urandom), 0);
    end

    @(negedge clk);
    drive(2'd2, 0, 0, 0, 0, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n = 0;
    tmo = 1;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      if (wr_en) n++;
      if (n == 1000) begin
        tmo = 0;
        break;
      end
    end
    chk("rstmid_reach", 32'(tmo), 0);
    reset = 1'b1;
    #1;
    chk("rstmid_wr_en", 32'(wr_en), 0);
    chk("rstmid_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_after_ready", 32'(cmd_ready), 1);
    chk("rstmid_after_wr_en", 32'(wr_en), 0);
    run_cmd("set_after_rst", 2'd0, 7, 7, 0, 0, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
